fetch_sequencer: RTL and testbench

//  Instruction fetch/PC sequencer at the opposite end of the control interface: issues instructions to the

---
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch / PC sequencer with one instruction in flight.
// It fetches the word at pc from instruction memory and hands it to decode. It then
// waits for the control unit's resolved outcome and uses it to pick the next pc.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | imem_req_o high at pc, waiting for imem_ack_i
// ISSUE   | instr_o/instr_valid_o presented, waiting for instr_ready_i
// RESOLVE | waiting for the ctrl_valid_i pulse carrying the outcome
// HALTED  | core stopped; only rst_n_i leaves this state
//
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   imem_req_o/addr_o/ack_i/rdata_i instruction memory handshake
//   instr_o/instr_valid_o/ready_i  issue handshake to decode
//   ctrl_valid_i, branch_i, jump_i, halt_i, cond_true_i, target_i  resolved outcome
//   flush_i, flush_pc_i            redirect request
//   link_pc_o, halted_o, retire_count_o  status outputs
module fetch_sequencer #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  input  logic                   ctrl_valid_i,
  input  logic                   branch_i,
  input  logic                   jump_i,
  input  logic                   halt_i,
  input  logic                   cond_true_i,
  input  logic [PC_WIDTH-1:0]    target_i,
  input  logic                   flush_i,
  input  logic [PC_WIDTH-1:0]    flush_pc_i,
  output logic [PC_WIDTH-1:0]    link_pc_o,
  output logic                   halted_o,
  output logic [CNT_WIDTH-1:0]   retire_count_o
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    ISSUE   = 2'd1,
    RESOLVE = 2'd2,
    HALTED  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   req_q, req_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [PC_WIDTH-1:0]    link_q, link_d;
  logic                   halted_q, halted_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [PC_WIDTH-1:0]    pc_inc;

  assign pc_inc = pc_q + PC_WIDTH'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= FETCH;
      pc_q     <= PC_WIDTH'(RESET_PC);
      req_q    <= 1'b0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      link_q   <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      link_q   <= link_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    link_d   = link_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;

    // A redirect overrides anything else this cycle. The request drops for
    // one cycle, and FETCH then re-raises it at the new pc.
    if (flush_i && state_q != HALTED) begin
      pc_d    = flush_pc_i;
      valid_d = 1'b0;
      req_d   = 1'b0;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          req_d = 1'b1;
          // An ack counts only while the request is actually visible.
          if (req_q && imem_ack_i) begin
            instr_d = imem_rdata_i;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready_i) begin
            valid_d = 1'b0;
            state_d = RESOLVE;
          end
        end
        RESOLVE: begin
          if (ctrl_valid_i) begin
            link_d = pc_inc;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            if (halt_i) begin
              halted_d = 1'b1;
              state_d  = HALTED;
            end else begin
              if (jump_i || (branch_i && cond_true_i)) pc_d = target_i;
              else                                     pc_d = pc_inc;
              // The request is raised on the resolve edge itself, which gives
              // the three-edge best-case loop.
              req_d   = 1'b1;
              state_d = FETCH;
            end
          end
        end
        HALTED: begin
          req_d   = 1'b0;
          valid_d = 1'b0;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign imem_req_o     = req_q;
  assign imem_addr_o    = pc_q;
  assign instr_o        = instr_q;
  assign instr_valid_o  = valid_q;
  assign link_pc_o      = link_q;
  assign halted_o       = halted_q;
  assign retire_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [15:0] imem_rdata_i = '0;
  logic [15:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        ctrl_valid_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        jump_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        cond_true_i = 1'b0;
  logic [15:0] target_i = '0;
  logic        flush_i = 1'b0;
  logic [15:0] flush_pc_i = '0;
  logic [15:0] link_pc_o;
  logic        halted_o;
  logic [15:0] retire_count_o;

  fetch_sequencer #(
    .PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0010), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .ctrl_valid_i(ctrl_valid_i), .branch_i(branch_i), .jump_i(jump_i), .halt_i(halt_i),
    .cond_true_i(cond_true_i), .target_i(target_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .link_pc_o(link_pc_o), .halted_o(halted_o), .retire_count_o(retire_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] rdata;
    logic        br;
    logic        jp;
    logic        cond;
    logic [15:0] tgt;
    int          stall;
    logic [15:0] exp_next;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] sb_q[$];
  logic [15:0] m_pc, m_link, m_cnt;
  int          total = 0;
  int          bad = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("req_timeout", {31'd0, imem_req_o}, 32'd1);
  endtask

  // One full fetch/issue/resolve transaction. exp_next < 0 form is not used;
  // halt leaves pc unchanged and is checked by the caller's model.
  task automatic do_instr(input logic [15:0] rdata, input logic br, input logic jp,
                          input logic ht, input logic cond, input logic [15:0] tgt,
                          input int stall, input logic [15:0] exp_next);
    logic [15:0] exp_instr;
    wait_req();
    chk("fetch_addr", imem_addr_o, m_pc);
    imem_ack_i   = 1'b1;
    imem_rdata_i = rdata;
    sb_q.push_back(rdata);
    tick();
    imem_ack_i   = 1'b0;
    imem_rdata_i = 16'hDEAD;
    chk("issue_valid", instr_valid_o, 1);
    chk("issue_req_low", imem_req_o, 0);
    if (sb_q.size() == 0) chk("sb_empty", 0, 1);
    else begin
      exp_instr = sb_q.pop_front();
      chk("issue_instr", instr_o, exp_instr);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_instr", instr_o, exp_instr);
      chk("stall_valid", instr_valid_o, 1);
      chk("stall_no_req", imem_req_o, 0);
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("accept_valid_low", instr_valid_o, 0);
    ctrl_valid_i = 1'b1;
    branch_i = br; jump_i = jp; halt_i = ht; cond_true_i = cond; target_i = tgt;
    tick();
    ctrl_valid_i = 1'b0;
    branch_i = 0; jump_i = 0; halt_i = 0; cond_true_i = 0;
    m_link = m_pc + 16'd1;
    m_cnt  = m_cnt + 16'd1;
    m_pc   = exp_next;
    chk("link_pc", link_pc_o, m_link);
    chk("retire_count", retire_count_o, m_cnt);
    chk("halted", halted_o, ht);
    chk("resolve_req", imem_req_o, !ht);
    chk("next_addr", imem_addr_o, m_pc);
  endtask

  initial begin
    //               rdata    br jp cond tgt      stall next
    vecs[0] = '{16'h2345, 0, 0, 0, 16'h0000, 0, 16'h0011};
    vecs[1] = '{16'h4111, 1, 0, 1, 16'h0040, 0, 16'h0040};
    vecs[2] = '{16'h4222, 1, 0, 0, 16'h0080, 0, 16'h0041};
    vecs[3] = '{16'h6333, 1, 1, 0, 16'h0200, 0, 16'h0200};
    vecs[4] = '{16'h8444, 0, 1, 0, 16'hFFFF, 0, 16'hFFFF};
    vecs[5] = '{16'h0555, 0, 0, 0, 16'h1234, 0, 16'h0000};
    vecs[6] = '{16'hA666, 0, 0, 0, 16'h0000, 5, 16'h0001};

    m_pc = 16'h0010; m_link = 0; m_cnt = 0;

    // reset values
    #13;
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 16'h0010);
    chk("rst_instr", instr_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_link", link_pc_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_count", retire_count_o, 0);
    tick();
    rst_n_i = 1'b1;
    chk("post_rst_req_low", imem_req_o, 0);
    tick();
    chk("first_req", imem_req_o, 1);
    chk("first_addr", imem_addr_o, 16'h0010);

    foreach (vecs[k])
      do_instr(vecs[k].rdata, vecs[k].br, vecs[k].jp, 1'b0, vecs[k].cond,
               vecs[k].tgt, vecs[k].stall, vecs[k].exp_next);

    // ctrl_valid while fetching is ignored
    ctrl_valid_i = 1'b1; jump_i = 1'b1; target_i = 16'h0777;
    tick();
    ctrl_valid_i = 1'b0; jump_i = 1'b0;
    chk("ign_ctrl_addr", imem_addr_o, m_pc);
    chk("ign_ctrl_count", retire_count_o, m_cnt);
    chk("ign_ctrl_req", imem_req_o, 1);

    // flush beats a same-cycle ack in FETCH
    imem_ack_i = 1'b1; imem_rdata_i = 16'hBEEF;
    flush_i = 1'b1; flush_pc_i = 16'h0300;
    tick();
    imem_ack_i = 1'b0; flush_i = 1'b0;
    chk("flushf_valid", instr_valid_o, 0);
    chk("flushf_req", imem_req_o, 0);
    tick();
    chk("flushf_req_again", imem_req_o, 1);
    chk("flushf_addr", imem_addr_o, 16'h0300);
    m_pc = 16'h0300;

    // flush in ISSUE beats a same-cycle ready
    imem_ack_i = 1'b1; imem_rdata_i = 16'h1111;
    tick();
    imem_ack_i = 1'b0;
    chk("flushi_pre_valid", instr_valid_o, 1);
    instr_ready_i = 1'b1; flush_i = 1'b1; flush_pc_i = 16'h0100;
    tick();
    instr_ready_i = 1'b0; flush_i = 1'b0;
    chk("flushi_valid", instr_valid_o, 0);
    chk("flushi_req", imem_req_o, 0);
    chk("flushi_count", retire_count_o, m_cnt);
    chk("flushi_link", link_pc_o, m_link);
    tick();
    chk("flushi_req_again", imem_req_o, 1);
    chk("flushi_addr", imem_addr_o, 16'h0100);
    m_pc = 16'h0100;

    // halt wins over a same-cycle jump; pc stays put
    do_instr(16'hE000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0999, 0, 16'h0100);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin flush_i = 1'b1; flush_pc_i = 16'h0500; end
      if (i == 6) flush_i = 1'b0;
      if (i == 8) begin imem_ack_i = 1'b1; ctrl_valid_i = 1'b1; end
      if (i == 9) begin imem_ack_i = 1'b0; ctrl_valid_i = 1'b0; end
      tick();
      chk("halt_req", imem_req_o, 0);
      chk("halt_flag", halted_o, 1);
      chk("halt_addr", imem_addr_o, 16'h0100);
      chk("halt_valid", instr_valid_o, 0);
    end
    chk("halt_count", retire_count_o, m_cnt);

    // asynchronous reset while a request is outstanding
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("rst_halted_clr", halted_o, 0);
    chk("rst_addr_again", imem_addr_o, 16'h0010);
    tick();
    rst_n_i = 1'b1;
    tick();
    chk("rst2_req", imem_req_o, 1);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("async_req", imem_req_o, 0);
    chk("async_addr", imem_addr_o, 16'h0010);
    chk("async_instr", instr_o, 0);
    chk("async_count", retire_count_o, 0);
    chk("async_link", link_pc_o, 0);
    chk("async_halted", halted_o, 0);
    tick();
    rst_n_i = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
